trdb_branch_ctrl: RTL and testbench

TRDB_BRANCH_CTRL -- requirements
Module: trdb_branch_ctrl

---
 rtl/trdb_branch_ctrl_if.sv | 37 +++
 rtl/trdb_branch_ctrl.sv | 90 +++++++++
 tb/tb_trdb_branch_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/trdb_branch_ctrl_if.sv
// Handshake bundle between the branch-trace controller, its branch map and the
// packet emitter; the controller takes the slave view.
interface trdb_branch_ctrl_if #(
    parameter int unsigned CNT_W  = 5,
    parameter int unsigned PCNT_W = 16
);
    logic              branch_valid_i;
    logic              branch_taken_i;
    logic              branch_ready_o;
    logic              disc_req_i;
    logic              map_valid_o;
    logic              map_taken_o;
    logic              map_flush_o;
    logic [CNT_W-1:0]  map_branches_i;
    logic              map_full_i;
    logic              map_empty_i;
    logic              pkt_req_o;
    logic              pkt_ack_i;
    logic              pkt_full_o;
    logic [CNT_W-1:0]  pkt_branches_o;
    logic [PCNT_W-1:0] pkt_cnt_o;
    logic              overflow_o;

    modport slave (
        input  branch_valid_i, branch_taken_i, disc_req_i, map_branches_i,
               map_full_i, map_empty_i, pkt_ack_i,
        output branch_ready_o, map_valid_o, map_taken_o, map_flush_o,
               pkt_req_o, pkt_full_o, pkt_branches_o, pkt_cnt_o, overflow_o
    );

    modport master (
        output branch_valid_i, branch_taken_i, disc_req_i, map_branches_i,
               map_full_i, map_empty_i, pkt_ack_i,
        input  branch_ready_o, map_valid_o, map_taken_o, map_flush_o,
               pkt_req_o, pkt_full_o, pkt_branches_o, pkt_cnt_o, overflow_o
    );
endinterface

// File: rtl/trdb_branch_ctrl.sv
// Branch-map controller: collects retired branch outcomes into the map and
// requests a packet when the map fills or a discontinuity forces early emission.
module trdb_branch_ctrl #(
    parameter int unsigned MAP_LEN = 31,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned PCNT_W  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    trdb_branch_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        COLLECT,
        REQ,
        FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic                pkt_full_q, pkt_full_d;
    logic [PCNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic                overflow_q, overflow_d;

    logic                branch_ready;
    logic                accept;
    logic                full_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= COLLECT;
            pkt_full_q <= 1'b0;
            pkt_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pkt_full_q <= pkt_full_d;
            pkt_cnt_q  <= pkt_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Full cause wins over a simultaneous discontinuity request.
    assign full_hit = bus.map_full_i
                    | (accept & (bus.map_branches_i == CNT_W'(MAP_LEN - 1)));

    always_comb begin
        state_d    = state_q;
        pkt_full_d = pkt_full_q;
        pkt_cnt_d  = pkt_cnt_q;
        overflow_d = overflow_q | (bus.branch_valid_i & ~branch_ready);
        case (state_q)
            COLLECT: begin
                if (full_hit) begin
                    state_d    = REQ;
                    pkt_full_d = 1'b1;
                end else if (bus.disc_req_i & (~bus.map_empty_i | accept)) begin
                    state_d    = REQ;
                    pkt_full_d = 1'b0;
                end
            end
            REQ: begin
                if (bus.pkt_ack_i) begin
                    state_d = FLUSH;
                    if (pkt_cnt_q != '1) begin
                        pkt_cnt_d = pkt_cnt_q + 1'b1;
                    end
                end
            end
            FLUSH:   state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Ready is gated by rst_ni so no write can leak out while reset is held.
    always_comb begin
        branch_ready = rst_ni & (state_q == COLLECT) & ~bus.map_full_i;
        accept       = bus.branch_valid_i & branch_ready;
    end

    assign bus.branch_ready_o = branch_ready;
    assign bus.map_valid_o    = accept;
    assign bus.map_taken_o    = bus.branch_taken_i;
    assign bus.map_flush_o    = (state_q == FLUSH);
    assign bus.pkt_req_o      = (state_q == REQ);
    assign bus.pkt_branches_o = (state_q == REQ) ? bus.map_branches_i : '0;
    assign bus.pkt_full_o     = pkt_full_q;
    assign bus.pkt_cnt_o      = pkt_cnt_q;
    assign bus.overflow_o     = overflow_q;

endmodule

// File: tb/tb_trdb_branch_ctrl.sv
// Bench for trdb_branch_ctrl: directed vector table, hand sequences for the
// full-map and reset corners, then random traffic against a behavioural model.
module tb_trdb_branch_ctrl;

    localparam int unsigned MAP_LEN = 31;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned PCNT_W  = 3;   // narrow so saturation is reached

    typedef struct packed {
        logic              rdy;
        logic              mv;
        logic              mt;
        logic              fl;
        logic              preq;
        logic              pf;
        logic [CNT_W-1:0]  pbr;
        logic [PCNT_W-1:0] cnt;
        logic              ovf;
    } outs_t;

    typedef struct {
        logic  v;
        logic  t;
        logic  d;
        logic  a;
        outs_t exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ff = 1'b0;
    logic [CNT_W-1:0] mcount;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    trdb_branch_ctrl_if #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) bus ();

    trdb_branch_ctrl #(
        .MAP_LEN(MAP_LEN),
        .CNT_W  (CNT_W),
        .PCNT_W (PCNT_W)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Branch map stand-in: counts writes, cleared by flush or its own reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  mcount <= '0;
        else if (bus.map_flush_o)    mcount <= '0;
        else if (bus.map_valid_o && mcount != CNT_W'(MAP_LEN)) mcount <= mcount + 1'b1;
    end

    assign bus.map_branches_i = mcount;
    assign bus.map_full_i     = (mcount == CNT_W'(MAP_LEN)) | ff;
    assign bus.map_empty_i    = (mcount == '0);

    function automatic outs_t mk(input int rdy, input int mv, input int mt,
                                 input int fl, input int preq, input int pf,
                                 input int pbr, input int cnt, input int ovf);
        outs_t o;
        o.rdy  = rdy[0];
        o.mv   = mv[0];
        o.mt   = mt[0];
        o.fl   = fl[0];
        o.preq = preq[0];
        o.pf   = pf[0];
        o.pbr  = pbr[CNT_W-1:0];
        o.cnt  = cnt[PCNT_W-1:0];
        o.ovf  = ovf[0];
        return o;
    endfunction

    task automatic drive(input logic v, input logic t, input logic d,
                         input logic a, input logic f);
        bus.branch_valid_i = v;
        bus.branch_taken_i = t;
        bus.disc_req_i     = d;
        bus.pkt_ack_i      = a;
        ff                 = f;
    endtask

    task automatic check(input outs_t exp, input string name);
        outs_t act;
        #1;
        act.rdy  = bus.branch_ready_o;
        act.mv   = bus.map_valid_o;
        act.mt   = bus.map_taken_o;
        act.fl   = bus.map_flush_o;
        act.preq = bus.pkt_req_o;
        act.pf   = bus.pkt_full_o;
        act.pbr  = bus.pkt_branches_o;
        act.cnt  = bus.pkt_cnt_o;
        act.ovf  = bus.overflow_o;
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got {rdy,mv,mt,fl,preq,pf,pbr,cnt,ovf}=%b,%b,%b,%b,%b,%b,%0d,%0d,%b required %b,%b,%b,%b,%b,%b,%0d,%0d,%b",
                     name, $time, act.rdy, act.mv, act.mt, act.fl, act.preq, act.pf, act.pbr, act.cnt, act.ovf,
                     exp.rdy, exp.mv, exp.mt, exp.fl, exp.preq, exp.pf, exp.pbr, exp.cnt, exp.ovf);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tbl [12];

    // Behavioural reference state for the random phase
    bit m_wait, m_flush, m_pf, m_ovf;
    int m_pcnt;

    initial begin
        //          v     t     d     a      rdy mv mt fl rq pf pbr cnt ovf
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0)}; // disc, empty map
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, mk(1, 1, 1, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0)}; // partial trigger
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 0, 2, 0, 0)};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 1, 0, 2, 0, 0)}; // disc absorbed, ack
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 0, 0, 0, 1, 0)};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, mk(1, 1, 1, 0, 0, 0, 0, 1, 0)}; // disc with 1st branch
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 1, 0, 1, 1, 0)}; // branch in REQ, first-cycle ack
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 0, 0, 0, 2, 1)};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 2, 1)}; // stray ack
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 2, 1)};

        // Reset: outputs forced low whatever the inputs do
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #3;
        check(mk(0, 0, 1, 0, 0, 0, 0, 0, 0), "reset0");
        next_cycle();
        check(mk(0, 0, 1, 0, 0, 0, 0, 0, 0), "reset1");
        next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].t, tbl[i].d, tbl[i].a, 1'b0);
            check(tbl[i].exp, $sformatf("tbl%0d", i));
            next_cycle();
        end

        // Fill the map; disc on the filling write must still report a full packet
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 1'(i % 2), 1'b0, 1'b0, 1'b0);
            check(mk(1, 1, i % 2, 0, 0, 0, 0, 2, 1), $sformatf("fill%0d", i));
            next_cycle();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check(mk(1, 1, 1, 0, 0, 0, 0, 2, 1), "fill30_disc");
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, (i == 2) ? 1'b1 : 1'b0, 1'b0);
            check(mk(0, 0, 0, 0, 1, 1, 31, 2, 1), $sformatf("full_req%0d", i));
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check(mk(0, 0, 0, 1, 0, 1, 0, 3, 1), "full_flush");
        next_cycle();
        check(mk(1, 0, 0, 0, 0, 1, 0, 3, 1), "full_ready");
        next_cycle();

        // Reset asserted mid-REQ
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check(mk(1, 1, 0, 0, 0, 1, 0, 3, 1), "rst_pre");
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check(mk(0, 0, 0, 0, 1, 0, 1, 3, 1), "rst_inreq");
        #2;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_async");
        next_cycle();
        check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_hold");
        next_cycle();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "rst_release");
        next_cycle();

        // Random traffic against the reference model
        m_wait = 0; m_flush = 0; m_pf = 0; m_ovf = 0; m_pcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic v, t, d, a, f, collecting, rdy, acc, full;
            outs_t exp;
            v = ($urandom_range(0, 9) < 6);
            t = 1'($urandom);
            d = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 9) < 3);
            f = ($urandom_range(0, 39) == 0);
            drive(v, t, d, a, f);

            full       = (int'(mcount) == MAP_LEN) || f;
            collecting = !m_wait && !m_flush;
            rdy        = collecting && !full;
            acc        = v && rdy;
            exp = mk(rdy, acc, t, m_flush, m_wait, m_pf,
                     m_wait ? int'(mcount) : 0, m_pcnt, m_ovf);
            check(exp, $sformatf("rand%0d", c));

            if (m_flush) begin
                m_flush = 0;
            end else if (m_wait) begin
                if (a) begin
                    m_wait  = 0;
                    m_flush = 1;
                    if (m_pcnt < (1 << PCNT_W) - 1) m_pcnt++;
                end
            end else if (full || (acc && int'(mcount) == MAP_LEN - 1)) begin
                m_wait = 1;
                m_pf   = 1;
            end else if (d && (mcount != 0 || acc)) begin
                m_wait = 1;
                m_pf   = 0;
            end
            if (v && !rdy) m_ovf = 1;
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
